// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, RX state encoding and a bit-reversal helper.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRE     = 2'd1,
      PAY     = 2'd2,
      DISCARD = 2'd3
   } rx_state_t;

   // The CRC register runs LSB-first, the residue constant is written MSB-first.
   function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// One byte-wide step of the reflected Ethernet CRC-32 (polynomial 0xEDB88320).
module crc32_d8 (
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) begin
            c = (c >> 1) ^ 32'hEDB8_8320;
         end else begin
            c = c >> 1;
         end
      end
      crc_out = c;
   end

endmodule

// File: rtl/gmii_rx_buf.sv
// GMII receive frame buffer: strips preamble/SFD and releases only complete, good frames.
// Optional FCS checking is enabled by defining GMII_RX_FCS_CHECK_EN.
import eth_pkg::*;

module gmii_rx_buf #(
   parameter int DEPTH     = 2048,
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1522
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic [7:0]  out_d,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        frame_drop,
   output logic [15:0] drop_count
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
   localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
   localparam logic [15:0] MIN_LEN    = MIN_FRAME[15:0];
   localparam logic [15:0] MAX_LEN    = MAX_FRAME[15:0];

   rx_state_t   state;
   logic [AW:0] wr_ptr;
   logic [AW:0] commit_ptr;
   logic [AW:0] rd_ptr;
   logic [8:0]  mem [DEPTH];
   logic [8:0]  rd_entry;
   logic [7:0]  hold;
   logic        hold_valid;
   logic [15:0] len;

   logic full;
   logic wr_req;
   logic wr_last;
   logic abort;
   logic mem_we;
   logic len_ok;
   logic crc_ok;
   logic frame_end;
   logic frame_good;
   logic drop_now;

   assign full       = (wr_ptr - rd_ptr) == FULL_LEVEL;
   assign len_ok     = (len >= MIN_LEN) && (len <= MAX_LEN);
   assign frame_end  = (state == PAY) && !gmii_rx_dv;
   assign frame_good = len_ok && crc_ok && !(wr_req && full);
   assign mem_we     = wr_req && !full && !abort;
   assign drop_now   = abort || (frame_end && !frame_good);

   // The held byte is flushed whenever a new byte arrives or the frame ends; only the final flush is tagged last.
   always_comb begin
      wr_req  = 1'b0;
      wr_last = 1'b0;
      abort   = 1'b0;
      if (state == PAY) begin
         wr_req  = hold_valid;
         wr_last = !gmii_rx_dv;
         if (gmii_rx_dv) begin
            abort = gmii_rx_er || (hold_valid && full) || (len == MAX_LEN);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr[AW-1:0]] <= {wr_last, hold};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         len        <= '0;
         frame_drop <= 1'b0;
         drop_count <= '0;
      end else begin
         frame_drop <= drop_now;
         if (drop_now && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end

         if (out_valid && out_ready) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         if (drop_now) begin
            wr_ptr <= commit_ptr;
         end else if (mem_we) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end

         case (state)
            IDLE: begin
               if (gmii_rx_dv) begin
                  state <= (gmii_rxd == PREAMBLE_BYTE) ? PRE : DISCARD;
               end
            end
            PRE: begin
               if (!gmii_rx_dv) begin
                  state <= IDLE;
               end else if (gmii_rxd == SFD_BYTE) begin
                  state      <= PAY;
                  len        <= '0;
                  hold_valid <= 1'b0;
               end else if (gmii_rxd != PREAMBLE_BYTE) begin
                  state <= DISCARD;
               end
            end
            PAY: begin
               if (!gmii_rx_dv) begin
                  state      <= IDLE;
                  hold_valid <= 1'b0;
                  if (frame_good) begin
                     commit_ptr <= wr_ptr + PTR_ONE;
                  end
               end else if (abort) begin
                  state      <= DISCARD;
                  hold_valid <= 1'b0;
               end else begin
                  hold       <= gmii_rxd;
                  hold_valid <= 1'b1;
                  len        <= len + 16'd1;
               end
            end
            default: begin
               if (!gmii_rx_dv) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef GMII_RX_FCS_CHECK_EN
   logic [31:0] crc;
   logic [31:0] crc_next;

   crc32_d8 u_crc (
      .crc_in  (crc),
      .data    (gmii_rxd),
      .crc_out (crc_next)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         crc <= CRC32_INIT;
      end else if ((state == PRE) && gmii_rx_dv && (gmii_rxd == SFD_BYTE)) begin
         crc <= CRC32_INIT;
      end else if ((state == PAY) && gmii_rx_dv) begin
         crc <= crc_next;
      end
   end

   assign crc_ok = (bit_reverse32(crc) == CRC32_RESIDUE);
`else
   assign crc_ok = 1'b1;
`endif

   // Only committed entries are visible, so a frame under construction never leaks out.
   assign out_valid = (rd_ptr != commit_ptr);
   assign rd_entry  = mem[rd_ptr[AW-1:0]];
   assign out_d     = out_valid ? rd_entry[7:0] : 8'h00;
   assign out_last  = out_valid ? rd_entry[8] : 1'b0;

endmodule
